// File: rtl/shift_pkg.sv
// Shared helpers for the pipelined signed barrel shifter: stage count and saturation limits.
package shift_pkg;

  // Each stage resolves two bits of the shift amount; an odd top bit gets its own stage.
  function automatic int nstg(input int sw);
    return (sw + 1) / 2;
  endfunction

  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/shift_pipe_stage.sv
// One registered radix-4 shift stage (radix-2 when the amount field has one bit left).
// SHIFT_PIPE_ROUND_EN: carry a guard bit on right shifts and round half-up in the last stage.
module shift_pipe_stage #(
  parameter int WIDTH = 24,
  parameter int TAGW  = 4,
  parameter int SHW   = 6,
  parameter int K     = 0,
  parameter bit LAST  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             d_valid,
  input  logic             d_left,
  input  logic             d_ovf,
  input  logic             d_guard,
  input  logic [TAGW-1:0]  d_tag,
  input  logic [SHW-1:0]   d_sh,
  input  logic [WIDTH-1:0] d_data,
  output logic             q_valid,
  output logic             q_left,
  output logic             q_ovf,
  output logic             q_guard,
  output logic [TAGW-1:0]  q_tag,
  output logic [SHW-1:0]   q_sh,
  output logic [WIDTH-1:0] q_data
);

  logic [1:0]       dg;
  logic [31:0]      n;
  logic [WIDTH-1:0] shl, back, nd;
  logic             ng, no;
`ifdef SHIFT_PIPE_ROUND_EN
  logic [WIDTH:0]   ext;
`endif

  assign dg = d_sh[2*K +: 2];
  assign n  = 32'(dg) << (2*K);

  always_comb begin
    nd   = d_data;
    ng   = d_guard;
    no   = d_ovf;
    shl  = '0;
    back = '0;
`ifdef SHIFT_PIPE_ROUND_EN
    ext  = '0;
`endif
    if (d_left) begin
      // Exact iff shifting back recovers the input; once saturated, data is frozen so its sign survives.
      shl  = d_data << n;
      back = $signed(shl) >>> n;
      if (!d_ovf) begin
        if (back != d_data) no = 1'b1;
        else                nd = shl;
      end
    end else begin
`ifdef SHIFT_PIPE_ROUND_EN
      ext = $signed({d_data, d_guard}) >>> n;
      nd  = ext[WIDTH:1];
      ng  = ext[0];
      if (LAST) nd = nd + {{(WIDTH-1){1'b0}}, ng};
`else
      nd = $signed(d_data) >>> n;
`endif
    end
    if (LAST) ng = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_left  <= 1'b0;
      q_ovf   <= 1'b0;
      q_guard <= 1'b0;
      q_tag   <= '0;
      q_sh    <= '0;
      q_data  <= '0;
    end else if (en) begin
      q_valid <= d_valid;
      q_left  <= d_left;
      q_ovf   <= no;
      q_guard <= ng;
      q_tag   <= d_tag;
      q_sh    <= d_sh;
      q_data  <= nd;
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined signed barrel shifter with valid/ready, saturating left shifts and a sticky overflow flag.
// SHIFT_PIPE_ROUND_EN selects round-half-up right shifts (handled inside the stages).
module shift_pipe import shift_pkg::*; #(
  parameter int WIDTH = 24,
  parameter int SW    = 5,
  parameter int TAGW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SW-1:0]    in_shift,
  input  logic             in_left,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAGW-1:0]  out_tag,
  output logic             out_ovf,
  output logic             ovf_sticky,
  input  logic             clr
);

  localparam int NSTG = nstg(SW);
  localparam int SHW  = 2 * NSTG;
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] MINV = WIDTH'(sat_min(WIDTH));

  // Index 0 is the input side, index k+1 the output register of stage k.
  logic [NSTG:0]            vld_pipe, lft, ovf, grd;
  logic [NSTG:0][TAGW-1:0]  tag;
  logic [NSTG:0][SHW-1:0]   shv;
  logic [NSTG:0][WIDTH-1:0] dat;
  logic                     en;
  logic                     unused_tail;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  assign vld_pipe[0] = in_valid;
  assign lft[0]      = in_left;
  assign ovf[0]      = 1'b0;
  assign grd[0]      = 1'b0;
  assign tag[0]      = in_tag;
  assign shv[0]      = SHW'(in_shift);
  assign dat[0]      = in_data;

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    shift_pipe_stage #(
      .WIDTH(WIDTH), .TAGW(TAGW), .SHW(SHW), .K(k), .LAST(k == NSTG - 1)
    ) u_stg (
      .clk(clk), .rst_n(rst_n), .en(en),
      .d_valid(vld_pipe[k]),   .d_left(lft[k]),   .d_ovf(ovf[k]),   .d_guard(grd[k]),
      .d_tag(tag[k]),          .d_sh(shv[k]),     .d_data(dat[k]),
      .q_valid(vld_pipe[k+1]), .q_left(lft[k+1]), .q_ovf(ovf[k+1]), .q_guard(grd[k+1]),
      .q_tag(tag[k+1]),        .q_sh(shv[k+1]),   .q_data(dat[k+1])
    );
  end

  assign out_valid   = vld_pipe[NSTG];
  assign out_tag     = tag[NSTG];
  assign out_ovf     = ovf[NSTG] & lft[NSTG];
  // Saturated samples keep the input's sign in the MSB because the stages stop shifting them.
  assign out_data    = out_ovf ? (dat[NSTG][WIDTH-1] ? MINV : MAXV) : dat[NSTG];
  assign unused_tail = ^{shv[NSTG], grd[NSTG]};

  always_ff @(posedge clk) begin
    if (!rst_n)                              ovf_sticky <= 1'b0;
    else if (out_valid && out_ready && out_ovf) ovf_sticky <= 1'b1;
    else if (clr)                            ovf_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_shift_pipe.sv
// Directed self-checking bench for shift_pipe (WIDTH=24, SW=5, TAGW=4).
module tb_shift_pipe;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, in_left, out_valid, out_ready, out_ovf, ovf_sticky, clr;
  logic [23:0] in_data, out_data;
  logic [4:0]  in_shift;
  logic [3:0]  in_tag, out_tag;
  int          n_assert = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  shift_pipe #(.WIDTH(24), .SW(5), .TAGW(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shift(in_shift), .in_left(in_left), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag), .out_ovf(out_ovf),
    .ovf_sticky(ovf_sticky), .clr(clr)
  );

  task automatic chk(input string tg, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tg, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One sample in, checked exactly three cycles later.
  task automatic run1(input string tg, input logic [23:0] d, input logic [4:0] s, input logic l,
                      input logic [23:0] ed, input logic eo);
    in_data = d; in_shift = s; in_left = l; in_tag = 4'h5; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk({tg, "_early"}, 32'(out_valid), 32'd0);
    tick();
    chk({tg, "_vld"},  32'(out_valid), 32'd1);
    chk({tg, "_data"}, 32'(out_data),  32'(ed));
    chk({tg, "_ovf"},  32'(out_ovf),   32'(eo));
  endtask

  initial begin
    logic [23:0] exp_r31, exp_p3, exp_m3;
    int sent, got, cyc;
    logic in_fire, out_fire;
`ifdef SHIFT_PIPE_ROUND_EN
    exp_r31 = 24'h000000; exp_p3 = 24'h000002; exp_m3 = 24'hFFFFFF;
`else
    exp_r31 = 24'hFFFFFF; exp_p3 = 24'h000001; exp_m3 = 24'hFFFFFE;
`endif
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shift = '0; in_left = 1'b0;
    in_tag = '0; out_ready = 1'b1; clr = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready),   32'd1);
    chk("rst_out_vld",  32'(out_valid),  32'd0);
    chk("rst_out_data", 32'(out_data),   32'd0);
    chk("rst_sticky",   32'(ovf_sticky), 32'd0);

    run1("r_s4",  24'h800000, 5'd4,  1'b0, 24'hF80000, 1'b0);
    run1("r_s31", 24'h800000, 5'd31, 1'b0, exp_r31,    1'b0);
    run1("l_123", 24'h000123, 5'd8,  1'b1, 24'h012300, 1'b0);
    tick();
    chk("sticky_clean", 32'(ovf_sticky), 32'd0);
    run1("l_sat_pos", 24'h400000, 5'd1, 1'b1, 24'h7FFFFF, 1'b1);
    tick();
    chk("sticky_set", 32'(ovf_sticky), 32'd1);
    run1("l_sat_neg", 24'hC00000, 5'd2, 1'b1, 24'h800000, 1'b1);
    clr = 1'b1;
    tick();
    chk("clr_vs_set", 32'(ovf_sticky), 32'd1);
    tick();
    clr = 1'b0;
    chk("clr_alone", 32'(ovf_sticky), 32'd0);
    run1("l_zero", 24'h000000, 5'd31, 1'b1, 24'h000000, 1'b0);
    run1("rnd_pos", 24'h000003, 5'd1, 1'b0, exp_p3, 1'b0);
    run1("rnd_neg", 24'hFFFFFD, 5'd1, 1'b0, exp_m3, 1'b0);
    run1("l_neg_ok", 24'hFFFFFF, 5'd23, 1'b1, 24'h800000, 1'b0);
    tick();

    // Backpressure stream: out_ready pattern 1,0,0 repeating.
    sent = 0; got = 0; cyc = 0;
    while (got < 10 && cyc < 200) begin
      out_ready = (cyc % 3 == 0);
      in_valid  = (sent < 10);
      in_data   = 24'(16 * sent + 256);
      in_shift  = 5'd4;
      in_left   = 1'b0;
      in_tag    = 4'(sent);
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (out_fire) begin
        chk("bp_tag",  32'(out_tag),  32'(got % 16));
        chk("bp_data", 32'(out_data), 32'(got + 16));
        got++;
      end
      @(posedge clk); #1;
      if (in_fire) sent++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_count", 32'(got), 32'd10);
    tick(); tick(); tick();

    // Reset with three samples in flight and the sticky flag set.
    run1("pre_rst_sat", 24'h400000, 5'd3, 1'b1, 24'h7FFFFF, 1'b1);
    tick();
    chk("pre_rst_sticky", 32'(ovf_sticky), 32'd1);
    for (int i = 0; i < 3; i++) begin
      in_data = 24'(i + 1); in_shift = 5'd0; in_left = 1'b0; in_tag = 4'(i); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("mid_rst_vld",    32'(out_valid),  32'd0);
    chk("mid_rst_sticky", 32'(ovf_sticky), 32'd0);
    rst_n = 1'b1;
    run1("post_rst", 24'h001000, 5'd4, 1'b0, 24'h000100, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
